// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Target end of the core's load/store port. Accepts one request at a time
//   over valid/ready, waits WAIT_STATES cycles, performs a little-endian
//   byte-lane access on an internal word array, then returns extended load
//   data or a store acknowledge over a valid/ready response channel.
//
// Parameters
//   DEPTH_WORDS   number of 32-bit words; word index = req_addr[31:2]
//   WAIT_STATES   extra cycles between accept and access (0..15)
//
// Optional feature (compile-time macro)
//   MISALIGN_TRAP_EN  defined: misaligned half/word accesses return rsp_err=1
//                     and never write. Undefined: low address bits below the
//                     access size are ignored.
//
// Ports
//   clk, rst                 clock (rising edge), async reset (active-low)
//   req_valid / req_ready    request handshake (ready only in IDLE)
//   req_write, req_addr      store/load select, byte address
//   req_size, req_unsigned   00 byte / 01 half / 10 word / 11 illegal, zero-ext
//   req_wdata                right-aligned store data
//   rsp_valid / rsp_ready    response handshake
//   rsp_rdata, rsp_err       extended load data (0 for stores/errors), error
//   busy                     high while waiting or holding a response
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt;
    logic        write_q, unsigned_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept, access, rsp_done;
    logic        misalign_err, acc_err;
    logic [1:0]  lane_off;
    logic [3:0]  byte_en;
    logic [31:0] wr_data, rd_word, rd_shift, rd_ext;
    logic [AW-1:0] word_idx;

    assign accept   = (state == S_IDLE) && req_valid;
    assign access   = (state == S_WAIT) && (wait_cnt == 4'd0);
    assign rsp_done = (state == S_RESP) && rsp_ready;

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

    // ---------------- FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // NOTE: defaults come first so every path assigns state_nxt and no latch
    // is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_valid)          state_nxt = S_WAIT;
            S_WAIT:  if (wait_cnt == 4'd0)   state_nxt = S_RESP;
            S_RESP:  if (rsp_ready)          state_nxt = S_IDLE;
            default:                         state_nxt = S_IDLE;
        endcase
    end

    // ---------------- Lane decode of the captured request ----------------
    always_comb begin
        lane_off = 2'b00;
        byte_en  = 4'b0000;
        wr_data  = wdata_q;
        case (size_q)
            2'b00: begin
                lane_off = addr_q[1:0];
                byte_en  = 4'b0001 << addr_q[1:0];
                wr_data  = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                // addr[0] is ignored: a half always occupies an aligned lane pair
                lane_off = {addr_q[1], 1'b0};
                byte_en  = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_data  = {2{wdata_q[15:0]}};
            end
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign_err = ((size_q == 2'b01) && addr_q[0]) ||
                          ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
`else
    assign misalign_err = 1'b0;
`endif

    assign acc_err  = (addr_q[31:2] >= DEPTH_LIM) || (size_q == 2'b11) || misalign_err;
    assign word_idx = addr_q[AW+1:2];

    // ---------------- Load path ----------------
    assign rd_word  = mem[word_idx];
    assign rd_shift = rd_word >> {lane_off, 3'b000};

    always_comb begin
        rd_ext = rd_shift;
        case (size_q)
            2'b00:   rd_ext = {{24{~unsigned_q & rd_shift[7]}},  rd_shift[7:0]};
            2'b01:   rd_ext = {{16{~unsigned_q & rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    // ---------------- Store path ----------------
    // NOTE: the array is storage, not control state, so it has no reset; the
    // write is qualified by the FSM, which reset forces to IDLE.
    always_ff @(posedge clk) begin
        if (access && write_q && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // ---------------- Capture, wait counter, response registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt   <= 4'd0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                write_q    <= req_write;
                unsigned_q <= req_unsigned;
                size_q     <= req_size;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                wait_cnt   <= WAIT_INIT;
            end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (access) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (write_q || acc_err) ? 32'd0 : rd_ext;
            end else if (rsp_done) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'd0;
            end
        end
    end

endmodule
